// File: rtl/sdram_bridge_pkg.sv
// Shared types and constants for the CPU-slot to SDRAM-controller bridge.
package sdram_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } bridge_state_t;

  localparam int         BRIDGE_TIMEOUT_DEF = 255;
  localparam logic [7:0] DOUT_IDLE          = 8'hFF;

endpackage

// File: rtl/sdram_bridge.sv
// Converts level-style CPU memory requests into one-cycle controller commands,
// stretches the CPU cycle while waiting, and serves repeat reads from a latch.
module sdram_bridge
  import sdram_bridge_pkg::*;
#(
  parameter int ADDR_W  = 25,
  parameter int TIMEOUT = BRIDGE_TIMEOUT_DEF
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              upload_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [7:0]        req_din_i,
  input  logic              req_we_i,
  input  logic              req_rd_i,
  output logic [7:0]        req_dout_o,
  output logic              req_ready_o,
  output logic              cpu_wait_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_din_o,
  output logic              mem_wr_o,
  output logic              mem_rd_o,
  input  logic              mem_ready_i,
  input  logic [7:0]        mem_dout_i,
  output logic              err_timeout_o
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  bridge_state_t     state_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_din_q;
  logic              mem_wr_q;
  logic              mem_rd_q;
  logic [7:0]        req_dout_q;
  logic              err_q;
  logic              served_q;
  logic              hit_valid_q;
  logic [ADDR_W-1:0] hit_addr_q;
  logic [7:0]        hit_data_q;
  logic [7:0]        cnt_q;
  logic              run_q;

  logic              start_s;
  logic              hit_s;
  logic              imm_s;
  logic [7:0]        imm_data_s;

  // Acceptance decode; reads answered without the controller (hit or upload) are "immediate".
  always_comb begin
    start_s = run_q & (state_q == IDLE) & (req_rd_i | req_we_i) & ~served_q;
    hit_s   = hit_valid_q & (req_addr_i == hit_addr_q);
    imm_s   = start_s & ~req_we_i & (upload_i | hit_s);
    if (upload_i) begin
      imm_data_s = DOUT_IDLE;
    end else begin
      imm_data_s = hit_data_q;
    end
  end

  // Bridge FSM with command, read-data, hit-latch and timeout registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_din_q   <= 8'h00;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      req_dout_q  <= DOUT_IDLE;
      err_q       <= 1'b0;
      served_q    <= 1'b0;
      hit_valid_q <= 1'b0;
      hit_addr_q  <= '0;
      hit_data_q  <= 8'h00;
      cnt_q       <= 8'd0;
      run_q       <= 1'b0;
    end else begin
      run_q    <= 1'b1;
      mem_wr_q <= 1'b0;
      mem_rd_q <= 1'b0;
      if (!req_rd_i && !req_we_i) begin
        served_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (start_s) begin
            if (imm_s) begin
              req_dout_q <= imm_data_s;
              served_q   <= 1'b1;
            end else begin
              mem_addr_q <= req_addr_i;
              mem_din_q  <= req_din_i;
              cnt_q      <= 8'd0;
              if (req_we_i) begin
                mem_wr_q <= 1'b1;
                state_q  <= WR;
              end else begin
                mem_rd_q <= 1'b1;
                state_q  <= RD;
              end
            end
          end
        end
        RD: begin
          if (mem_ready_i) begin
            req_dout_q  <= mem_dout_i;
            hit_addr_q  <= mem_addr_q;
            hit_data_q  <= mem_dout_i;
            hit_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (cnt_q == TO_LAST) begin
            req_dout_q <= DOUT_IDLE;
            err_q      <= 1'b1;
            state_q    <= DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        WR: begin
          if (mem_ready_i) begin
            if (mem_addr_q == hit_addr_q) begin
              hit_data_q <= mem_din_q;
            end
            state_q <= DONE;
          end else if (cnt_q == TO_LAST) begin
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE: begin
          served_q <= 1'b1;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
      // Uploaded data bypasses the latch, so it can never be trusted during upload.
      if (upload_i) begin
        hit_valid_q <= 1'b0;
      end
    end
  end

  assign req_dout_o    = imm_s ? imm_data_s : req_dout_q;
  assign cpu_wait_o    = (start_s & ~imm_s) | (state_q == RD) | (state_q == WR);
  assign req_ready_o   = ((state_q == IDLE) & ~start_s) | (state_q == DONE);
  assign mem_addr_o    = mem_addr_q;
  assign mem_din_o     = mem_din_q;
  assign mem_wr_o      = mem_wr_q;
  assign mem_rd_o      = mem_rd_q;
  assign err_timeout_o = err_q;

endmodule

// File: tb/tb_sdram_bridge.sv
// Directed bench for sdram_bridge: per-cycle vector table plus multi-cycle sequences.
module tb_sdram_bridge;

  localparam int ADDR_W = 25;
  localparam logic [24:0] A  = 25'h01234;
  localparam logic [24:0] B  = 25'h00777;
  localparam logic [24:0] Z  = 25'h00000;
  localparam int NV = 28;

  logic              clk_i = 1'b0;
  logic              reset_n_i;
  logic              upload_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [7:0]        req_din_i;
  logic              req_we_i;
  logic              req_rd_i;
  logic [7:0]        req_dout_o;
  logic              req_ready_o;
  logic              cpu_wait_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_din_o;
  logic              mem_wr_o;
  logic              mem_rd_o;
  logic              mem_ready_i;
  logic [7:0]        mem_dout_i;
  logic              err_timeout_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        rd, we, rdy_in;
    logic [7:0]  mdout;
    logic [24:0] addr;
    logic [7:0]  din;
    logic        e_rd, e_wr, e_wait, e_rdy;
    logic [7:0]  e_dout;
    logic [24:0] e_maddr;
    logic [7:0]  e_mdin;
  } vec_t;

  vec_t tv [NV];

  sdram_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .upload_i(upload_i),
    .req_addr_i(req_addr_i), .req_din_i(req_din_i), .req_we_i(req_we_i), .req_rd_i(req_rd_i),
    .req_dout_o(req_dout_o), .req_ready_o(req_ready_o), .cpu_wait_o(cpu_wait_o),
    .mem_addr_o(mem_addr_o), .mem_din_o(mem_din_o), .mem_wr_o(mem_wr_o), .mem_rd_o(mem_rd_o),
    .mem_ready_i(mem_ready_i), .mem_dout_i(mem_dout_i), .err_timeout_o(err_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic vec_t v(input logic rd, we, rdy, input logic [7:0] md, input logic [24:0] ad,
                             input logic [7:0] di, input logic erd, ewr, ewt, erdy,
                             input logic [7:0] edo, input logic [24:0] ema, input logic [7:0] emd);
    vec_t r;
    r.rd = rd; r.we = we; r.rdy_in = rdy; r.mdout = md; r.addr = ad; r.din = di;
    r.e_rd = erd; r.e_wr = ewr; r.e_wait = ewt; r.e_rdy = erdy;
    r.e_dout = edo; r.e_maddr = ema; r.e_mdin = emd;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One CPU request with a simple controller answering lat cycles after the command (lat<=0: never).
  task automatic do_req(input logic rd, input logic we, input logic [24:0] addr, input logic [7:0] din,
                        input int lat, input logic [7:0] mdout,
                        output int waits, output int rdp, output int wrp,
                        output logic [7:0] d_first, output logic [7:0] d_last, output logic done);
    int cd;
    cd = -1; waits = 0; rdp = 0; wrp = 0; done = 1'b0; d_first = 8'h00; d_last = 8'h00;
    @(posedge clk_i); #1;
    req_rd_i = rd; req_we_i = we; req_addr_i = addr; req_din_i = din;
    for (int c = 0; c < 40; c++) begin
      mem_ready_i = (cd == 0);
      mem_dout_i  = (cd == 0) ? mdout : 8'h00;
      @(negedge clk_i);
      if (c == 0) d_first = req_dout_o;
      if (mem_rd_o) rdp++;
      if (mem_wr_o) wrp++;
      if ((mem_rd_o || mem_wr_o) && lat > 0) cd = lat;
      if (cpu_wait_o) waits++;
      if (c > 0 && req_ready_o) begin
        done = 1'b1;
        d_last = req_dout_o;
        break;
      end
      @(posedge clk_i); #1;
      if (cd >= 0) cd--;
    end
    mem_ready_i = 1'b0;
    @(posedge clk_i); #1;
    req_rd_i = 1'b0; req_we_i = 1'b0;
    @(negedge clk_i);
  endtask

  int waits, rdp, wrp, wr_total;
  logic [7:0] d_first, d_last;
  logic done;

  initial begin
    tv[0]  = v(1,0,0,8'h00,A,8'h00, 0,0,1,0,8'hFF,Z,8'h00);
    tv[1]  = v(1,0,0,8'h00,A,8'h00, 1,0,1,0,8'hFF,A,8'h00);
    tv[2]  = v(1,0,0,8'h00,A,8'h00, 0,0,1,0,8'hFF,A,8'h00);
    tv[3]  = v(1,0,0,8'h00,A,8'h00, 0,0,1,0,8'hFF,A,8'h00);
    tv[4]  = v(1,0,1,8'h5A,A,8'h00, 0,0,1,0,8'hFF,A,8'h00);
    tv[5]  = v(1,0,0,8'h00,A,8'h00, 0,0,0,1,8'h5A,A,8'h00);
    tv[6]  = v(1,0,0,8'h00,A,8'h00, 0,0,0,1,8'h5A,A,8'h00);
    tv[7]  = v(1,0,0,8'h00,A,8'h00, 0,0,0,1,8'h5A,A,8'h00);
    tv[8]  = v(0,0,0,8'h00,A,8'h00, 0,0,0,1,8'h5A,A,8'h00);
    tv[9]  = v(1,0,0,8'h00,A,8'h00, 0,0,0,0,8'h5A,A,8'h00);
    tv[10] = v(1,0,0,8'h00,A,8'h00, 0,0,0,1,8'h5A,A,8'h00);
    tv[11] = v(0,0,0,8'h00,A,8'h00, 0,0,0,1,8'h5A,A,8'h00);
    tv[12] = v(0,1,0,8'h00,A,8'hA5, 0,0,1,0,8'h5A,A,8'h00);
    tv[13] = v(0,1,0,8'h00,A,8'hA5, 0,1,1,0,8'h5A,A,8'hA5);
    tv[14] = v(0,1,1,8'h00,A,8'hA5, 0,0,1,0,8'h5A,A,8'hA5);
    tv[15] = v(0,1,0,8'h00,A,8'hA5, 0,0,0,1,8'h5A,A,8'hA5);
    tv[16] = v(0,0,0,8'h00,A,8'h00, 0,0,0,1,8'h5A,A,8'hA5);
    tv[17] = v(1,0,0,8'h00,A,8'h00, 0,0,0,0,8'hA5,A,8'hA5);
    tv[18] = v(1,0,0,8'h00,A,8'h00, 0,0,0,1,8'hA5,A,8'hA5);
    tv[19] = v(0,0,0,8'h00,A,8'h00, 0,0,0,1,8'hA5,A,8'hA5);
    tv[20] = v(1,1,0,8'h00,B,8'h3C, 0,0,1,0,8'hA5,A,8'hA5);
    tv[21] = v(1,1,0,8'h00,B,8'h3C, 0,1,1,0,8'hA5,B,8'h3C);
    tv[22] = v(1,1,1,8'h00,B,8'h3C, 0,0,1,0,8'hA5,B,8'h3C);
    tv[23] = v(1,1,0,8'h00,B,8'h3C, 0,0,0,1,8'hA5,B,8'h3C);
    tv[24] = v(0,0,0,8'h00,B,8'h00, 0,0,0,1,8'hA5,B,8'h3C);
    tv[25] = v(1,0,0,8'h00,A,8'h00, 0,0,0,0,8'hA5,B,8'h3C);
    tv[26] = v(0,0,1,8'h11,A,8'h00, 0,0,0,1,8'hA5,B,8'h3C);
    tv[27] = v(0,0,0,8'h00,A,8'h00, 0,0,0,1,8'hA5,B,8'h3C);

    reset_n_i = 1'b0; upload_i = 1'b0; req_addr_i = A; req_din_i = 8'h00;
    req_we_i = 1'b0; req_rd_i = 1'b1; mem_ready_i = 1'b0; mem_dout_i = 8'h00;
    repeat (3) @(negedge clk_i);
    chk("rst mem_rd", mem_rd_o, 1'b0);
    chk("rst mem_wr", mem_wr_o, 1'b0);
    chk("rst cpu_wait", cpu_wait_o, 1'b0);
    chk("rst req_dout", req_dout_o, 8'hFF);
    chk("rst err", err_timeout_o, 1'b0);
    chk("rst req_ready", req_ready_o, 1'b1);
    chk("rst mem_addr", mem_addr_o, 25'h0);
    @(posedge clk_i); #1;
    req_rd_i = 1'b0; reset_n_i = 1'b1;
    repeat (2) @(posedge clk_i);

    for (int i = 0; i < NV; i++) begin
      @(posedge clk_i); #1;
      req_rd_i = tv[i].rd; req_we_i = tv[i].we; req_addr_i = tv[i].addr; req_din_i = tv[i].din;
      mem_ready_i = tv[i].rdy_in; mem_dout_i = tv[i].mdout;
      @(negedge clk_i);
      chk($sformatf("v%0d mem_rd", i), mem_rd_o, tv[i].e_rd);
      chk($sformatf("v%0d mem_wr", i), mem_wr_o, tv[i].e_wr);
      chk($sformatf("v%0d cpu_wait", i), cpu_wait_o, tv[i].e_wait);
      chk($sformatf("v%0d req_ready", i), req_ready_o, tv[i].e_rdy);
      chk($sformatf("v%0d req_dout", i), req_dout_o, tv[i].e_dout);
      chk($sformatf("v%0d mem_addr", i), mem_addr_o, tv[i].e_maddr);
      chk($sformatf("v%0d mem_din", i), mem_din_o, tv[i].e_mdin);
    end
    chk("err before timeout", err_timeout_o, 1'b0);

    // Timeout: read with no controller answer.
    do_req(1'b1, 1'b0, 25'h00010, 8'h00, 0, 8'h00, waits, rdp, wrp, d_first, d_last, done);
    chk("to done", done, 1'b1);
    chk("to wait cycles", waits, 9);
    chk("to mem_rd pulses", rdp, 1);
    chk("to req_dout", d_last, 8'hFF);
    chk("to err", err_timeout_o, 1'b1);
    // Latch still valid after a timeout.
    do_req(1'b1, 1'b0, A, 8'h00, 2, 8'hEE, waits, rdp, wrp, d_first, d_last, done);
    chk("to hit done", done, 1'b1);
    chk("to hit mem_rd", rdp, 0);
    chk("to hit wait", waits, 0);
    chk("to hit dout", d_first, 8'hA5);
    // Normal miss after a timeout; err stays sticky.
    do_req(1'b1, 1'b0, 25'h00020, 8'h00, 2, 8'hC3, waits, rdp, wrp, d_first, d_last, done);
    chk("post-to done", done, 1'b1);
    chk("post-to wait", waits, 4);
    chk("post-to mem_rd", rdp, 1);
    chk("post-to dout", d_last, 8'hC3);
    chk("post-to err sticky", err_timeout_o, 1'b1);

    // Upload mode: four writes, then an ignored read.
    upload_i = 1'b1;
    wr_total = 0;
    for (int k = 0; k < 4; k++) begin
      do_req(1'b0, 1'b1, A + 25'(k), 8'h10 + 8'(k), 2, 8'h00, waits, rdp, wrp, d_first, d_last, done);
      wr_total += wrp;
      chk($sformatf("up%0d done", k), done, 1'b1);
      chk($sformatf("up%0d wait", k), waits, 4);
    end
    chk("up mem_wr total", wr_total, 4);
    do_req(1'b1, 1'b0, 25'h00020, 8'h00, 2, 8'h99, waits, rdp, wrp, d_first, d_last, done);
    chk("up read dout", d_first, 8'hFF);
    chk("up read mem_rd", rdp, 0);
    chk("up read wait", waits, 0);
    // 0x00020 was latched before upload; it must now miss.
    upload_i = 1'b0;
    do_req(1'b1, 1'b0, 25'h00020, 8'h00, 1, 8'h66, waits, rdp, wrp, d_first, d_last, done);
    chk("post-up miss mem_rd", rdp, 1);
    chk("post-up miss dout", d_last, 8'h66);
    chk("post-up miss wait", waits, 3);

    // Reset while a write is outstanding.
    upload_i = 1'b1;
    @(posedge clk_i); #1;
    req_we_i = 1'b1; req_addr_i = 25'h00005; req_din_i = 8'h99;
    @(negedge clk_i);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("mid mem_wr", mem_wr_o, 1'b1);
    chk("mid cpu_wait", cpu_wait_o, 1'b1);
    chk("mid err", err_timeout_o, 1'b1);
    @(posedge clk_i); #1;
    reset_n_i = 1'b0; req_we_i = 1'b0; upload_i = 1'b0;
    @(negedge clk_i);
    chk("mrst mem_wr", mem_wr_o, 1'b0);
    chk("mrst mem_rd", mem_rd_o, 1'b0);
    chk("mrst cpu_wait", cpu_wait_o, 1'b0);
    chk("mrst req_ready", req_ready_o, 1'b1);
    chk("mrst req_dout", req_dout_o, 8'hFF);
    chk("mrst err", err_timeout_o, 1'b0);
    chk("mrst mem_addr", mem_addr_o, 25'h0);
    chk("mrst mem_din", mem_din_o, 8'h00);
    @(posedge clk_i); #1;
    reset_n_i = 1'b1; mem_ready_i = 1'b1; mem_dout_i = 8'h42;
    @(negedge clk_i);
    @(posedge clk_i); #1;
    mem_ready_i = 1'b0;
    @(negedge clk_i);
    chk("orphan req_ready", req_ready_o, 1'b1);
    chk("orphan cpu_wait", cpu_wait_o, 1'b0);
    chk("orphan req_dout", req_dout_o, 8'hFF);
    chk("orphan mem_wr", mem_wr_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
